// File: rtl/branch_compare_stage.sv
// Two-register branch comparison stage with valid/ready handshake and flush.
// Optional taken / not-taken statistics counters are built when BRANCH_STATS_EN is defined.
module comparator_eq #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         eq_o
);
  logic [N-1:0] diff;

  assign diff = a_i ^ b_i;
  assign eq_o = ~|diff;
endmodule

module branch_compare_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   funct3,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         taken,
  output logic         illegal,
  output logic [15:0]  taken_count,
  output logic [15:0]  not_taken_count
);
  typedef enum logic [2:0] {
    F_BEQ  = 3'b000,
    F_BNE  = 3'b001,
    F_RSV2 = 3'b010,
    F_RSV3 = 3'b011,
    F_BLT  = 3'b100,
    F_BGE  = 3'b101,
    F_BLTU = 3'b110,
    F_BGEU = 3'b111
  } funct3_e;

  logic         s1_valid_q, s1_valid_d;
  logic [N-1:0] s1_a_q, s1_b_q;
  funct3_e      s1_f3_q;
  logic         s2_valid_q, s2_valid_d;
  logic         s2_taken_q, s2_illegal_q;

  logic         s1_adv;
  logic         accept;
  logic         out_fire;
  logic         eq, lt, ltu;
  logic         res_taken, res_illegal;

  assign s1_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s1_adv;
  assign accept   = in_valid & in_ready & ~flush;
  assign out_fire = s2_valid_q & out_ready & ~flush;

  comparator_eq #(.N(N)) u_eq (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .eq_o (eq)
  );

  assign lt  = $signed(s1_a_q) < $signed(s1_b_q);
  assign ltu = s1_a_q < s1_b_q;

  always_comb begin
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    case (s1_f3_q)
      F_BEQ:   res_taken = eq;
      F_BNE:   res_taken = ~eq;
      F_BLT:   res_taken = lt;
      F_BGE:   res_taken = ~lt;
      F_BLTU:  res_taken = ltu;
      F_BGEU:  res_taken = ~ltu;
      default: res_illegal = 1'b1;
    endcase
  end

  // Flush wins over acceptance, advance and result transfer in the same cycle.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (accept)              s1_valid_d = 1'b1;
      else if (s1_adv)         s1_valid_d = 1'b0;
      if (s1_adv)              s2_valid_d = 1'b1;
      else if (out_ready)      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_f3_q      <= F_BEQ;
      s2_valid_q   <= 1'b0;
      s2_taken_q   <= 1'b0;
      s2_illegal_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (accept) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_f3_q <= funct3_e'(funct3);
      end
      if (s1_adv && !flush) begin
        s2_taken_q   <= res_taken;
        s2_illegal_q <= res_illegal;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign taken     = s2_valid_q & s2_taken_q;
  assign illegal   = s2_valid_q & s2_illegal_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] nt_cnt_q, nt_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    nt_cnt_d    = nt_cnt_q;
    if (out_fire && s2_taken_q && taken_cnt_q != 16'hFFFF)
      taken_cnt_d = taken_cnt_q + 16'd1;
    if (out_fire && !s2_taken_q && !s2_illegal_q && nt_cnt_q != 16'hFFFF)
      nt_cnt_d = nt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_cnt_q <= '0;
      nt_cnt_q    <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      nt_cnt_q    <= nt_cnt_d;
    end
  end

  assign taken_count     = taken_cnt_q;
  assign not_taken_count = nt_cnt_q;
`else
  logic unused_fire;

  assign unused_fire     = out_fire;
  assign taken_count     = '0;
  assign not_taken_count = '0;
`endif
endmodule

// File: tb/tb_branch_compare_stage.sv
// Directed bench for branch_compare_stage; counter checks follow BRANCH_STATS_EN.
module tb_branch_compare_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  funct3;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic        illegal;
  logic [15:0] taken_count;
  logic [15:0] not_taken_count;

  int passed = 0;
  int total  = 0;
  int exp_tc = 0;
  int exp_ntc = 0;

  branch_compare_stage #(.N(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .a               (a),
    .b               (b),
    .funct3          (funct3),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .taken           (taken),
    .illegal         (illegal),
    .taken_count     (taken_count),
    .not_taken_count (not_taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_tc"}, {16'h0, taken_count}, exp_tc[31:0]);
    chk({tag, "_ntc"}, {16'h0, not_taken_count}, exp_ntc[31:0]);
  endtask

  task automatic note_result(input logic t, input logic ill);
`ifdef BRANCH_STATS_EN
    if (!ill) begin
      if (t) exp_tc++;
      else   exp_ntc++;
    end
`endif
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] f);
    a = va;
    b = vb;
    funct3 = f;
    in_valid = 1'b1;
  endtask

  task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [2:0] f, input logic et, input logic ei);
    out_ready = 1'b1;
    drive(va, vb, f);
    #1;
    chk({tag, "_inrdy"}, {31'h0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "_ov_early"}, {31'h0, out_valid}, 32'd0);
    step();
    chk({tag, "_ov"}, {31'h0, out_valid}, 32'd1);
    chk({tag, "_taken"}, {31'h0, taken}, {31'h0, et});
    chk({tag, "_illegal"}, {31'h0, illegal}, {31'h0, ei});
    step();
    note_result(et, ei);
    chk({tag, "_ov_done"}, {31'h0, out_valid}, 32'd0);
    chk({tag, "_taken_idle"}, {31'h0, taken}, 32'd0);
    chk_counts(tag);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; funct3 = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_ov", {31'h0, out_valid}, 32'd0);
    chk("rst_taken", {31'h0, taken}, 32'd0);
    chk("rst_illegal", {31'h0, illegal}, 32'd0);
    chk_counts("rst");
    rst = 1'b1;
    step();
    chk("post_rst_inrdy", {31'h0, in_ready}, 32'd1);

    run_one("beq_eq",    32'd5,          32'd5,          3'b000, 1'b1, 1'b0);
    run_one("beq_ne",    32'd5,          32'd6,          3'b000, 1'b0, 1'b0);
    run_one("bne_eq",    32'd5,          32'd5,          3'b001, 1'b0, 1'b0);
    run_one("blt_neg",   32'hFFFFFFFF,   32'd1,          3'b100, 1'b1, 1'b0);
    run_one("bltu_big",  32'hFFFFFFFF,   32'd1,          3'b110, 1'b0, 1'b0);
    run_one("bgeu_big",  32'hFFFFFFFF,   32'd1,          3'b111, 1'b1, 1'b0);
    run_one("bge_neg",   32'hFFFFFFFF,   32'd1,          3'b101, 1'b0, 1'b0);
    run_one("blt_pos",   32'd1,          32'hFFFFFFFF,   3'b100, 1'b0, 1'b0);
    run_one("bltu_eq",   32'h80000000,   32'h80000000,   3'b110, 1'b0, 1'b0);
    run_one("bgeu_eq",   32'h80000000,   32'h80000000,   3'b111, 1'b1, 1'b0);
    run_one("ill_011",   32'd7,          32'd7,          3'b011, 1'b0, 1'b1);
    run_one("ill_010",   32'd7,          32'd7,          3'b010, 1'b0, 1'b1);

    // Backpressure: four requests, consumer stalled, then drained in order.
    out_ready = 1'b0;
    drive(32'd1, 32'd1, 3'b000);
    step();
    drive(32'd1, 32'd1, 3'b001);
    #1;
    chk("bp_inrdy_s2empty", {31'h0, in_ready}, 32'd1);
    step();
    drive(32'd3, 32'd3, 3'b010);
    #1;
    chk("bp_inrdy_full", {31'h0, in_ready}, 32'd0);
    chk("bp_r0_ov", {31'h0, out_valid}, 32'd1);
    chk("bp_r0_taken", {31'h0, taken}, 32'd1);
    step();
    chk("bp_hold_ov", {31'h0, out_valid}, 32'd1);
    chk("bp_hold_taken", {31'h0, taken}, 32'd1);
    chk("bp_hold_illegal", {31'h0, illegal}, 32'd0);
    chk("bp_hold_inrdy", {31'h0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_inrdy_release", {31'h0, in_ready}, 32'd1);
    step();
    note_result(1'b1, 1'b0);
    drive(32'd0, 32'd1, 3'b110);
    chk("bp_r1_ov", {31'h0, out_valid}, 32'd1);
    chk("bp_r1_taken", {31'h0, taken}, 32'd0);
    chk("bp_r1_illegal", {31'h0, illegal}, 32'd0);
    step();
    note_result(1'b0, 1'b0);
    in_valid = 1'b0;
    chk("bp_r2_ov", {31'h0, out_valid}, 32'd1);
    chk("bp_r2_taken", {31'h0, taken}, 32'd0);
    chk("bp_r2_illegal", {31'h0, illegal}, 32'd1);
    step();
    chk("bp_r3_ov", {31'h0, out_valid}, 32'd1);
    chk("bp_r3_taken", {31'h0, taken}, 32'd1);
    chk("bp_r3_illegal", {31'h0, illegal}, 32'd0);
    step();
    note_result(1'b1, 1'b0);
    chk("bp_drained_ov", {31'h0, out_valid}, 32'd0);
    chk_counts("bp");

    // Flush with both stages full and a new request offered.
    out_ready = 1'b0;
    drive(32'd9, 32'd9, 3'b000);
    step();
    drive(32'd2, 32'd9, 3'b100);
    step();
    chk("fl_pre_ov", {31'h0, out_valid}, 32'd1);
    drive(32'd4, 32'd4, 3'b000);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_ov", {31'h0, out_valid}, 32'd0);
    chk("fl_taken", {31'h0, taken}, 32'd0);
    chk("fl_inrdy", {31'h0, in_ready}, 32'd1);
    step();
    chk("fl_dropped_ov", {31'h0, out_valid}, 32'd0);
    step();
    chk("fl_dropped_ov2", {31'h0, out_valid}, 32'd0);
    chk_counts("fl");

    // Reset in the middle of operation.
    out_ready = 1'b0;
    drive(32'd8, 32'd8, 3'b000);
    step();
    in_valid = 1'b0;
    step();
    chk("mr_pre_ov", {31'h0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    exp_tc = 0;
    exp_ntc = 0;
    chk("mr_ov", {31'h0, out_valid}, 32'd0);
    chk("mr_taken", {31'h0, taken}, 32'd0);
    chk_counts("mr");
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mr_inrdy", {31'h0, in_ready}, 32'd1);
    step();
    chk("mr_no_ghost", {31'h0, out_valid}, 32'd0);
    step();
    chk("mr_no_ghost2", {31'h0, out_valid}, 32'd0);

`ifdef BRANCH_STATS_EN
    // Saturation of the taken counter.
    out_ready = 1'b1;
    drive(32'd0, 32'd0, 3'b000);
    repeat (65537) step();
    in_valid = 1'b0;
    step();
    step();
    chk("sat_tc", {16'h0, taken_count}, 32'h0000FFFF);
    chk("sat_ntc", {16'h0, not_taken_count}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("sat_rst_tc", {16'h0, taken_count}, 32'd0);
    chk("sat_rst_ov", {31'h0, out_valid}, 32'd0);
    chk("sat_rst_taken", {31'h0, taken}, 32'd0);
    rst = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
